// File: rtl/wb_sram_bridge_pkg.sv
// Shared types and defaults for the Wishbone-to-async-SRAM bridge.
// The optional read buffer is enabled by defining SRAM_RDBUF_EN.
package wb_sram_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_ACK  = 2'd3
  } state_e;

  localparam int DEF_RD_WAIT = 2;
  localparam int DEF_WR_WAIT = 2;
  localparam int CNT_W       = 8;

`ifdef SRAM_RDBUF_EN
  localparam bit RDBUF_EN = 1'b1;
`else
  localparam bit RDBUF_EN = 1'b0;
`endif

endpackage

// File: rtl/wb_sram_bridge_wait_cnt.sv
// Loadable down-counter with a zero flag; times the OE/WE strobe width.
module sram_wait_cnt #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/wb_sram_bridge.sv
// Wishbone classic slave driving a 16-bit asynchronous SRAM with timed strobes.
// Define SRAM_RDBUF_EN to add a one-word read buffer that short-cuts repeated reads.
module wb_sram_bridge
  import wb_sram_bridge_pkg::*;
#(
  parameter int ADDR_W  = 18,
  parameter int RD_WAIT = DEF_RD_WAIT,
  parameter int WR_WAIT = DEF_WR_WAIT
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [15:0]       wb_dat_i,
  output logic [15:0]       wb_dat_o,
  input  logic [19:1]       wb_adr_i,
  input  logic              wb_we_i,
  input  logic              wb_tga_i,
  input  logic [1:0]        wb_sel_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [15:0]       sram_dq_i,
  output logic [15:0]       sram_dq_o,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [1:0]        sram_bw_n,
  output logic [1:0]        dbg_state_o
);

  if (RD_WAIT < 1 || WR_WAIT < 1 || ADDR_W < 1 || ADDR_W > 19) begin : g_bad_param
    $error("wb_sram_bridge: RD_WAIT/WR_WAIT must be >= 1 and ADDR_W in 1..19");
  end

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic              ce_n_q, oe_n_q, we_n_q, dq_oe_q;
  logic              ce_n_d, oe_n_d, we_n_d, dq_oe_d;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       dq_o_q, dat_o_q;
  logic [1:0]        bw_n_q;
  logic              req, start_sram, rd_done, buf_hit;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0]  cnt_val;
  logic [ADDR_W-1:0] adr_word;
  logic [15:0]       buf_dat;
  logic              unused_adr;

  assign req        = wb_stb_i & wb_cyc_i & ~wb_tga_i;
  assign adr_word   = wb_adr_i[ADDR_W:1];
  assign unused_adr = ^wb_adr_i ^ RDBUF_EN;

`ifdef SRAM_RDBUF_EN
  logic              buf_vld_q;
  logic [ADDR_W-1:0] buf_tag_q;
  logic [15:0]       buf_dat_q;

  assign buf_hit = (state_q == ST_IDLE) && req && !wb_we_i && buf_vld_q && (buf_tag_q == adr_word);
  assign buf_dat = buf_dat_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      buf_vld_q <= 1'b0;
      buf_tag_q <= '0;
      buf_dat_q <= '0;
    end else if (start_sram && wb_we_i) begin
      buf_vld_q <= 1'b0;
    end else if (rd_done) begin
      buf_vld_q <= 1'b1;
      buf_tag_q <= addr_q;
      buf_dat_q <= sram_dq_i;
    end
  end
`else
  assign buf_hit = 1'b0;
  assign buf_dat = 16'h0000;
`endif

  sram_wait_cnt #(.W(CNT_W)) u_wait_cnt (
    .clk_i     (wb_clk_i),
    .rst_i     (wb_rst_i),
    .load_i    (cnt_load),
    .load_val_i(cnt_val),
    .dec_i     (cnt_dec),
    .zero_o    (cnt_zero)
  );

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    cnt_load   = 1'b0;
    cnt_val    = '0;
    cnt_dec    = 1'b0;
    rd_done    = 1'b0;
    start_sram = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (buf_hit) begin
          state_d = ST_ACK;
          we_d    = 1'b0;
        end else if (req) begin
          start_sram = 1'b1;
          we_d       = wb_we_i;
          cnt_load   = 1'b1;
          if (wb_we_i) begin
            state_d = ST_WR;
            cnt_val = CNT_W'(WR_WAIT - 1);
          end else begin
            state_d = ST_RD;
            cnt_val = CNT_W'(RD_WAIT - 1);
          end
        end
      end
      ST_RD: begin
        if (cnt_zero) begin
          rd_done = 1'b1;
          state_d = ST_ACK;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_WR: begin
        if (cnt_zero) state_d = ST_ACK;
        else          cnt_dec = 1'b1;
      end
      ST_ACK: begin
        if (!(wb_stb_i && wb_cyc_i)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Pad strobes are registered from the next state; write data stays driven through ACK for hold.
    ce_n_d  = !((state_d == ST_RD) || (state_d == ST_WR));
    oe_n_d  = (state_d != ST_RD);
    we_n_d  = (state_d != ST_WR);
    dq_oe_d = (state_d == ST_WR) || ((state_d == ST_ACK) && we_d);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      dq_oe_q <= 1'b0;
      addr_q  <= '0;
      dq_o_q  <= '0;
      bw_n_q  <= 2'b11;
      dat_o_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      dq_oe_q <= dq_oe_d;
      if (start_sram) addr_q <= adr_word;
      if (start_sram && wb_we_i) begin
        dq_o_q <= wb_dat_i;
        bw_n_q <= ~wb_sel_i;
      end else if ((state_q == ST_ACK) && (state_d == ST_IDLE)) begin
        bw_n_q <= 2'b11;
      end
      if (rd_done)      dat_o_q <= sram_dq_i;
      else if (buf_hit) dat_o_q <= buf_dat;
    end
  end

  assign wb_ack_o    = (state_q == ST_ACK) & wb_stb_i & wb_cyc_i;
  assign wb_dat_o    = dat_o_q;
  assign sram_addr   = addr_q;
  assign sram_dq_o   = dq_o_q;
  assign sram_dq_oe  = dq_oe_q;
  assign sram_ce_n   = ce_n_q;
  assign sram_oe_n   = oe_n_q;
  assign sram_we_n   = we_n_q;
  assign sram_bw_n   = bw_n_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram_bridge.sv
// Directed bench for wb_sram_bridge with a behavioural async SRAM model.
module tb_wb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] wb_dat_i = '0;
  logic [15:0] wb_dat_o;
  logic [19:1] wb_adr = '0;
  logic        wb_we = 1'b0, wb_tga = 1'b0, wb_stb = 1'b0, wb_cyc = 1'b0;
  logic [1:0]  wb_sel = 2'b00;
  logic        wb_ack_o;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n;
  logic [1:0]  sram_bw_n, dbg_state;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];
  int          oe_low, we_low, ce_starts, ack_rises;
  logic        ce_prev = 1'b1, ack_prev = 1'b0;
  logic [1:0]  wr_bw;
  logic [7:0]  ce_addr_q[$];
  logic        ack_dq_oe, ack_we_n, ack_ce_n, ack_after_drop;

  always #5 clk = ~clk;

  wb_sram_bridge dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_adr_i(wb_adr), .wb_we_i(wb_we), .wb_tga_i(wb_tga), .wb_sel_i(wb_sel),
    .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc), .wb_ack_o(wb_ack_o),
    .sram_addr(sram_addr), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_bw_n(sram_bw_n), .dbg_state_o(dbg_state)
  );

  // SRAM model: combinational read, byte-lane writes while WE and CE are low.
  assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[7:0]] : 16'h0000;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_bw_n[0]) mem[sram_addr[7:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_bw_n[1]) mem[sram_addr[7:0]][15:8] = sram_dq_o[15:8];
    end
  end

  always @(negedge clk) begin
    if (!sram_oe_n) oe_low++;
    if (!sram_we_n) begin
      we_low++;
      wr_bw = sram_bw_n;
    end
    if (!sram_ce_n && ce_prev) begin
      ce_starts++;
      ce_addr_q.push_back(sram_addr[7:0]);
    end
    ce_prev = sram_ce_n;
    if (wb_ack_o && !ack_prev) ack_rises++;
    ack_prev = wb_ack_o;
  end

  task automatic clr_mon();
    oe_low = 0; we_low = 0; ce_starts = 0; ack_rises = 0; wr_bw = 2'b11;
    ce_addr_q.delete();
  endtask

  // Called #1 after a posedge; returns #1 after the edge where the bridge is back in IDLE.
  task automatic wb_cycle(input logic we, input logic [19:1] adr, input logic [15:0] dat,
                          input logic [1:0] sel, output logic [15:0] rdat, output int lat);
    wb_we = we; wb_adr = adr; wb_dat_i = dat; wb_sel = sel; wb_tga = 1'b0;
    wb_stb = 1'b1; wb_cyc = 1'b1;
    lat = 0;
    while (lat < 50) begin
      @(posedge clk); lat++; #1;
      if (wb_ack_o) break;
    end
    rdat = wb_dat_o;
    ack_dq_oe = sram_dq_oe; ack_we_n = sram_we_n; ack_ce_n = sram_ce_n;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    #1 ack_after_drop = wb_ack_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (wb_dat_o !== 16'h0) begin errors++; $display("FAIL reset_dat_o: got %h want 0000", wb_dat_o); end
    checks++; if (sram_addr !== 18'h0) begin errors++; $display("FAIL reset_addr: got %h want 0", sram_addr); end
    checks++; if (sram_dq_o !== 16'h0) begin errors++; $display("FAIL reset_dq_o: got %h want 0000", sram_dq_o); end
    checks++; if ({sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n} !== 4'b0111) begin
      errors++; $display("FAIL reset_ctrl: got oe/ce/oe_n/we_n=%b want 0111", {sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n}); end
    checks++; if (sram_bw_n !== 2'b11) begin errors++; $display("FAIL reset_bw_n: got %b want 11", sram_bw_n); end
    checks++; if (wb_ack_o !== 1'b0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL reset_ack_state: got ack=%b state=%0d want 0/0", wb_ack_o, dbg_state); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    logic [15:0] d; int lat;
    clr_mon();
    wb_cycle(1'b0, 19'h00010, 16'h0, 2'b11, d, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++; if (d !== 16'hBEEF) begin errors++; $display("FAIL read_data: got %h want beef", d); end
    checks++; if (oe_low !== 2) begin errors++; $display("FAIL read_oe_width: got %0d want 2", oe_low); end
    checks++; if (ack_after_drop !== 1'b0) begin errors++; $display("FAIL read_ack_drop: got %b want 0", ack_after_drop); end
    checks++; if (ce_starts !== 1 || ack_rises !== 1) begin
      errors++; $display("FAIL read_pulses: got ce=%0d ack=%0d want 1/1", ce_starts, ack_rises); end
  endtask

  task automatic test_byte_write();
    logic [15:0] d; int lat;
    clr_mon();
    wb_cycle(1'b1, 19'h00020, 16'h1277, 2'b10, d, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL bwr_latency: got %0d want 3", lat); end
    checks++; if (wr_bw !== 2'b01) begin errors++; $display("FAIL bwr_bw_n: got %b want 01", wr_bw); end
    checks++; if (we_low !== 2) begin errors++; $display("FAIL bwr_we_width: got %0d want 2", we_low); end
    checks++; if ({ack_dq_oe, ack_we_n, ack_ce_n} !== 3'b111) begin
      errors++; $display("FAIL bwr_ack_pads: got dq_oe/we_n/ce_n=%b want 111", {ack_dq_oe, ack_we_n, ack_ce_n}); end
    checks++; if (mem[8'h20] !== 16'h12C3) begin errors++; $display("FAIL bwr_mem: got %h want 12c3", mem[8'h20]); end
    checks++; if (sram_bw_n !== 2'b11 || sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL bwr_idle_pads: got bw_n=%b dq_oe=%b want 11/0", sram_bw_n, sram_dq_oe); end
  endtask

  task automatic test_sel0_write();
    logic [15:0] d; int lat;
    clr_mon();
    wb_cycle(1'b1, 19'h00050, 16'h0000, 2'b00, d, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sel0_latency: got %0d want 3", lat); end
    checks++; if (wr_bw !== 2'b11 || mem[8'h50] !== 16'h7777) begin
      errors++; $display("FAIL sel0_nochange: got bw_n=%b mem=%h want 11/7777", wr_bw, mem[8'h50]); end
  endtask

  task automatic test_unaligned();
    logic [15:0] d0, d1; int l0, l1;
    clr_mon();
    wb_cycle(1'b0, 19'h00010, 16'h0, 2'b10, d0, l0);
    wb_cycle(1'b0, 19'h00011, 16'h0, 2'b01, d1, l1);
    checks++; if (d0 !== 16'hBEEF || d1 !== 16'h1234) begin
      errors++; $display("FAIL unal_data: got %h %h want beef 1234", d0, d1); end
    checks++; if (l0 !== 3 || l1 !== 3 || ack_rises !== 2) begin
      errors++; $display("FAIL unal_acks: got lat %0d %0d acks %0d want 3 3 2", l0, l1, ack_rises); end
    checks++;
    if (ce_addr_q.size() != 2) begin
      errors++; $display("FAIL unal_addrs: got %0d sram cycles want 2", ce_addr_q.size());
    end else if (ce_addr_q[0] !== 8'h10 || ce_addr_q[1] !== 8'h11) begin
      errors++; $display("FAIL unal_addrs: got %h %h want 10 11", ce_addr_q[0], ce_addr_q[1]);
    end
  endtask

  task automatic test_alias();
    logic [15:0] d; int lat;
    wb_cycle(1'b0, 19'h40011, 16'h0, 2'b11, d, lat);
    checks++; if (d !== 16'h1234 || sram_addr !== 18'h00011) begin
      errors++; $display("FAIL alias: got data %h addr %h want 1234 00011", d, sram_addr); end
  endtask

  task automatic test_cyc_drop();
    clr_mon();
    wb_we = 1'b1; wb_adr = 19'h00040; wb_dat_i = 16'hCAFE; wb_sel = 2'b11; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    wb_stb = 1'b0; wb_cyc = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    checks++; if (mem[8'h40] !== 16'hCAFE || we_low !== 2) begin
      errors++; $display("FAIL cycdrop_write: got mem=%h we_low=%0d want cafe/2", mem[8'h40], we_low); end
    checks++; if (ack_rises !== 0 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL cycdrop_noack: got acks=%0d state=%0d want 0/0", ack_rises, dbg_state); end
  endtask

  task automatic test_tga();
    clr_mon();
    wb_we = 1'b0; wb_adr = 19'h00010; wb_tga = 1'b1; wb_stb = 1'b1; wb_cyc = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (ack_rises !== 0 || ce_starts !== 0 || wb_ack_o !== 1'b0) begin
      errors++; $display("FAIL tga_ignored: got acks=%0d ce=%0d want 0/0", ack_rises, ce_starts); end
    wb_stb = 1'b0; wb_cyc = 1'b0; wb_tga = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_write();
    logic [15:0] d; int lat;
    wb_we = 1'b1; wb_adr = 19'h00060; wb_dat_i = 16'h5555; wb_sel = 2'b11; wb_stb = 1'b1; wb_cyc = 1'b1;
    @(posedge clk); #1;
    checks++; if (sram_we_n !== 1'b0) begin errors++; $display("FAIL rstwr_started: got we_n=%b want 0", sram_we_n); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if ({sram_we_n, sram_ce_n, sram_dq_oe} !== 3'b110 || dbg_state !== 2'd0) begin
      errors++; $display("FAIL rstwr_abort: got we_n/ce_n/dq_oe=%b state=%0d want 110/0",
                         {sram_we_n, sram_ce_n, sram_dq_oe}, dbg_state); end
    wb_stb = 1'b0; wb_cyc = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    wb_cycle(1'b0, 19'h00010, 16'h0, 2'b11, d, lat);
    checks++; if (d !== 16'hBEEF || lat !== 3) begin
      errors++; $display("FAIL rstwr_recover: got %h lat %0d want beef 3", d, lat); end
  endtask

  task automatic test_rdbuf();
    logic [15:0] d; int lat;
    clr_mon();
    wb_cycle(1'b0, 19'h00030, 16'h0, 2'b11, d, lat);
    wb_cycle(1'b0, 19'h00030, 16'h0, 2'b11, d, lat);
`ifdef SRAM_RDBUF_EN
    checks++; if (lat !== 1 || ce_starts !== 1 || d !== 16'h3030) begin
      errors++; $display("FAIL rdbuf_hit: got lat %0d ce %0d data %h want 1 1 3030", lat, ce_starts, d); end
`else
    checks++; if (lat !== 3 || ce_starts !== 2 || d !== 16'h3030) begin
      errors++; $display("FAIL rdbuf_off: got lat %0d ce %0d data %h want 3 2 3030", lat, ce_starts, d); end
`endif
    wb_cycle(1'b1, 19'h00030, 16'hA1B2, 2'b11, d, lat);
    clr_mon();
    wb_cycle(1'b0, 19'h00030, 16'h0, 2'b11, d, lat);
    checks++; if (lat !== 3 || ce_starts !== 1 || d !== 16'hA1B2) begin
      errors++; $display("FAIL rdbuf_inval: got lat %0d ce %0d data %h want 3 1 a1b2", lat, ce_starts, d); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h10] = 16'hBEEF; mem[8'h11] = 16'h1234; mem[8'h20] = 16'hA5C3;
    mem[8'h30] = 16'h3030; mem[8'h50] = 16'h7777;
    clr_mon();
    test_reset();
    test_read();
    test_byte_write();
    test_sel0_write();
    test_unaligned();
    test_alias();
    test_cyc_drop();
    test_tga();
    test_reset_mid_write();
    test_rdbuf();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
